// File: rtl/fuzz_frame_pkg.sv
// Shared constants, state encoding and a frame-packing helper for the fuzz result serializer.
// Latency: none (package only).
// Backpressure: not applicable.
package fuzz_frame_pkg;

  localparam int FRAME_W = 82;
  localparam int BEAT_W  = 8;
  localparam int CNT_W   = 16;
  localparam int SIG_W   = 32;
  localparam int NBEATS  = (FRAME_W + BEAT_W - 1) / BEAT_W;

  // Result frame field layout, LSB upward.
  localparam int PAD_LSB = 0;
  localparam int F5_LSB  = 1;
  localparam int F5_W    = 12;
  localparam int F6_LSB  = 13;
  localparam int F6_W    = 22;
  localparam int F7_LSB  = 35;
  localparam int F7_W    = 18;
  localparam int F8_LSB  = 53;
  localparam int F8_W    = 11;
  localparam int F9_LSB  = 64;
  localparam int F9_W    = 18;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  // Assemble a result frame from its fields.
  function automatic logic [FRAME_W-1:0] pack_frame(
    input logic [F9_W-1:0] f9,
    input logic [F8_W-1:0] f8,
    input logic [F7_W-1:0] f7,
    input logic [F6_W-1:0] f6,
    input logic [F5_W-1:0] f5,
    input logic            pad
  );
    logic [FRAME_W-1:0] fr;
    fr = '0;
    fr[F9_LSB +: F9_W] = f9;
    fr[F8_LSB +: F8_W] = f8;
    fr[F7_LSB +: F7_W] = f7;
    fr[F6_LSB +: F6_W] = f6;
    fr[F5_LSB +: F5_W] = f5;
    fr[PAD_LSB]        = pad;
    return fr;
  endfunction

endpackage

// File: rtl/fuzz_sig_fold.sv
// Next running signature: rotate-left-by-one of the old value XOR the 32-bit word fold of the frame.
// Latency: combinational.
// Backpressure: none; caller decides when to commit the result.
module fuzz_sig_fold #(
  parameter int FRAME_W = 82
) (
  input  logic [FRAME_W-1:0] frame_i,
  input  logic [31:0]        sig_i,
  output logic [31:0]        sig_o
);
  import fuzz_frame_pkg::*;

  localparam int NWORDS = (FRAME_W + SIG_W - 1) / SIG_W;

  logic [NWORDS*SIG_W-1:0] frame_ext;
  logic [SIG_W-1:0]        fold;

  // Zero-extend to whole words, XOR the words together, then mix into the rotated signature.
  always_comb begin
    frame_ext = (NWORDS*SIG_W)'(frame_i);
    fold      = '0;
    for (int w = 0; w < NWORDS; w++) begin
      fold = fold ^ frame_ext[w*SIG_W +: SIG_W];
    end
    sig_o = {sig_i[SIG_W-2:0], sig_i[SIG_W-1]} ^ fold;
  end

endmodule

// File: rtl/fuzz_frame_serializer.sv
// Accepts one packed result frame and streams it LSB-first as byte beats; keeps signature, frame count, sticky pad error.
// Latency: first beat valid the cycle after acceptance; 12-cycle frame period (13 with FUZZ_FRAME_PARITY_EN parity beat).
// Backpressure: out_ready low holds the current beat; in_ready is high only while idle, so frames never overlap.
module fuzz_frame_serializer #(
  parameter int FRAME_W = 82,
  parameter int BEAT_W  = 8,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [FRAME_W-1:0] in_frame,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BEAT_W-1:0]  out_data,
  output logic               out_last,
  output logic [31:0]        sig,
  output logic [CNT_W-1:0]   frame_cnt,
  output logic               err_pad
);
  import fuzz_frame_pkg::*;

  localparam int NDATA = (FRAME_W + BEAT_W - 1) / BEAT_W;
`ifdef FUZZ_FRAME_PARITY_EN
  localparam int NTOT  = NDATA + 1;
`else
  localparam int NTOT  = NDATA;
`endif
  localparam int SHREG_W = NTOT * BEAT_W;
  localparam int IDX_W   = $clog2(NTOT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NTOT - 1);

  state_e                 state_q, state_d;
  logic [SHREG_W-1:0]     shreg_q, shreg_d;
  logic [IDX_W-1:0]       beat_idx_q, beat_idx_d;
  logic [31:0]            sig_q, sig_d;
  logic [CNT_W-1:0]       frame_cnt_q, frame_cnt_d;
  logic                   err_pad_q, err_pad_d;

  logic [NDATA*BEAT_W-1:0] data_ext;
  logic [SHREG_W-1:0]      load_vec;
  logic [31:0]             sig_next;

  fuzz_sig_fold #(
    .FRAME_W (FRAME_W)
  ) u_sig_fold (
    .frame_i (in_frame),
    .sig_i   (sig_q),
    .sig_o   (sig_next)
  );

`ifdef FUZZ_FRAME_PARITY_EN
  logic [BEAT_W-1:0] parity;

  // Build the shift-register image: zero-extended frame with the XOR of its data beats on top.
  always_comb begin
    data_ext = (NDATA*BEAT_W)'(in_frame);
    parity   = '0;
    for (int b = 0; b < NDATA; b++) begin
      parity = parity ^ data_ext[b*BEAT_W +: BEAT_W];
    end
    load_vec = {parity, data_ext};
  end
`else
  // Build the shift-register image: the frame zero-extended to whole beats.
  always_comb begin
    data_ext = (NDATA*BEAT_W)'(in_frame);
    load_vec = data_ext;
  end
`endif

  // Next-state and output decode; statistics update only on the accept cycle.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    beat_idx_d  = beat_idx_q;
    sig_d       = sig_q;
    frame_cnt_d = frame_cnt_q;
    err_pad_d   = err_pad_q;

    in_ready  = (state_q == IDLE);
    out_valid = (state_q == SEND);
    out_data  = (state_q == SEND) ? shreg_q[BEAT_W-1:0] : '0;
    out_last  = (state_q == SEND) && (beat_idx_q == LAST_IDX);

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          shreg_d     = load_vec;
          beat_idx_d  = '0;
          state_d     = SEND;
          sig_d       = sig_next;
          frame_cnt_d = frame_cnt_q + 1'b1;
          err_pad_d   = err_pad_q | in_frame[PAD_LSB];
        end
      end
      SEND: begin
        if (out_ready) begin
          if (beat_idx_q == LAST_IDX) begin
            state_d = IDLE;
          end else begin
            shreg_d    = shreg_q >> BEAT_W;
            beat_idx_d = beat_idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and statistics registers; reset drops any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      beat_idx_q  <= '0;
      sig_q       <= '0;
      frame_cnt_q <= '0;
      err_pad_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      beat_idx_q  <= beat_idx_d;
      sig_q       <= sig_d;
      frame_cnt_q <= frame_cnt_d;
      err_pad_q   <= err_pad_d;
    end
  end

  assign sig       = sig_q;
  assign frame_cnt = frame_cnt_q;
  assign err_pad   = err_pad_q;

endmodule

// File: tb/tb_fuzz_frame_serializer.sv
// Scoreboard bench for the frame serializer: expected beats queued at drive time, popped as beats are accepted.
// Latency: checks accept-to-ready period and same-cycle statistics update.
// Backpressure: fixed stall window and random out_ready phases.
module tb_fuzz_frame_serializer;
  import fuzz_frame_pkg::*;

`ifdef FUZZ_FRAME_PARITY_EN
  localparam int NB = NBEATS + 1;
`else
  localparam int NB = NBEATS;
`endif

  typedef struct packed {
    logic       last;
    logic [7:0] dat;
  } beat_t;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [FRAME_W-1:0] in_frame;
  logic               out_valid;
  logic               out_ready;
  logic [BEAT_W-1:0]  out_data;
  logic               out_last;
  logic [31:0]        sig;
  logic [CNT_W-1:0]   frame_cnt;
  logic               err_pad;

  fuzz_frame_serializer #(
    .FRAME_W (FRAME_W),
    .BEAT_W  (BEAT_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_frame  (in_frame),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .sig       (sig),
    .frame_cnt (frame_cnt),
    .err_pad   (err_pad)
  );

  beat_t       expq[$];
  int          n_total = 0;
  int          n_bad   = 0;
  int          cyc     = 0;
  int          acc_cyc = 0;
  int          beat_in_frame = 0;
  int          stall_beat = -1;
  int          stall_left = 0;
  bit          rnd_ready  = 1'b0;
  bit          hold_valid = 1'b0;
  logic [31:0] m_sig;
  logic [15:0] m_cnt;
  logic        m_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Bench-side signature model: bit i of the frame lands in fold bit i mod 32.
  function automatic logic [31:0] model_sig(input logic [31:0] s, input logic [FRAME_W-1:0] f);
    logic [31:0] fd;
    fd = '0;
    for (int i = 0; i < FRAME_W; i++) fd[i % 32] = fd[i % 32] ^ f[i];
    return {s[30:0], s[31]} ^ fd;
  endfunction

  // Queue the expected beats of one frame and advance the statistics model.
  task automatic push_frame(input logic [FRAME_W-1:0] f);
    logic [7:0] d;
    logic [7:0] par;
    int         pos;
    par = '0;
    for (int b = 0; b < NBEATS; b++) begin
      d = '0;
      for (int k = 0; k < 8; k++) begin
        pos = b * 8 + k;
        if (pos < FRAME_W) d[k] = f[pos];
      end
      par = par ^ d;
      expq.push_back('{last: (b == NB - 1), dat: d});
    end
`ifdef FUZZ_FRAME_PARITY_EN
    expq.push_back('{last: 1'b1, dat: par});
`endif
    m_sig = model_sig(m_sig, f);
    m_cnt = m_cnt + 16'd1;
    m_err = m_err | f[0];
  endtask

  // Present a frame, wait for it to be taken, then check the same-cycle statistics update.
  task automatic start_frame(input logic [FRAME_W-1:0] f);
    int n;
    push_frame(f);
    in_frame = f;
    in_valid = 1'b1;
    for (n = 0; n < 300 && !in_ready; n++) @(negedge clk);
    if (!in_ready) check_eq("accept_timeout", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    acc_cyc = cyc;
    if (!hold_valid) in_valid = 1'b0;
    check_eq("sig_acc", sig, m_sig);
    check_eq("cnt_acc", {16'b0, frame_cnt}, {16'b0, m_cnt});
    check_eq("err_acc", {31'b0, err_pad}, {31'b0, m_err});
  endtask

  // Wait until every queued beat has been seen and the block is idle again.
  task automatic drain(output int period);
    int n;
    for (n = 0; n < 400 && !(expq.size() == 0 && in_ready); n++) begin
      if (out_valid) check_eq("rdy_in_send", {31'b0, in_ready}, 32'd0);
      @(negedge clk);
    end
    if (!(expq.size() == 0 && in_ready)) check_eq("drain_timeout", expq.size(), 32'd0);
    period = cyc - acc_cyc + 1;
  endtask

  // Beat monitor and out_ready driver, all on the falling edge.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        expq.delete();
        beat_in_frame = 0;
        out_ready = 1'b1;
      end else begin
        if (rnd_ready) out_ready = ($urandom_range(0, 2) != 0);
        else if (out_valid && beat_in_frame == stall_beat && stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
        end else out_ready = 1'b1;
        if (out_valid) begin
          if (expq.size() == 0) check_eq("no_beat_expected", {31'b0, out_valid}, 32'd0);
          else begin
            check_eq("beat_dat", {24'b0, out_data}, {24'b0, expq[0].dat});
            check_eq("beat_last", {31'b0, out_last}, {31'b0, expq[0].last});
            if (out_ready) begin
              if (expq[0].last) beat_in_frame = 0;
              else beat_in_frame++;
              void'(expq.pop_front());
            end
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [FRAME_W-1:0] f2, f3, fe;
    int per, n;

    rst = 1'b1; in_valid = 1'b0; in_frame = '0;
    m_sig = '0; m_cnt = '0; m_err = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check_eq("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check_eq("rst_out_last", {31'b0, out_last}, 32'd0);
    check_eq("rst_out_data", {24'b0, out_data}, 32'd0);
    check_eq("rst_sig", sig, 32'd0);
    check_eq("rst_cnt", {16'b0, frame_cnt}, 32'd0);
    check_eq("rst_err", {31'b0, err_pad}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Reference frame: bit 81 and low byte A4.
    f2 = '0; f2[81] = 1'b1; f2[7:0] = 8'hA4;
    start_frame(f2);
    drain(per);
    check_eq("period", per, NB + 1);
    check_eq("sig_f1", sig, 32'h000200A4);
    check_eq("cnt_f1", {16'b0, frame_cnt}, 32'd1);
    check_eq("err_f1", {31'b0, err_pad}, 32'd0);
    start_frame(f2);
    drain(per);
    check_eq("sig_f2", sig, 32'h000601EC);
    check_eq("cnt_f2", {16'b0, frame_cnt}, 32'd2);

    // Stall at beat 4 for 3 cycles with in_valid held high across the frame.
    f3 = pack_frame(18'h3A5C1, 11'h6B3, 18'h1F00F, 22'h2AAAAA, 12'h9C3, 1'b0);
    stall_beat = 4; stall_left = 3; hold_valid = 1'b1;
    start_frame(f3);
    drain(per);
    check_eq("stall_period", per, NB + 4);
    check_eq("cnt_hold", {16'b0, frame_cnt}, {16'b0, m_cnt});
    stall_beat = -1; hold_valid = 1'b0;
    start_frame(f3);
    drain(per);

    // Sticky pad error.
    fe = pack_frame(18'h00001, 11'h001, 18'h00002, 22'h000003, 12'h004, 1'b1);
    start_frame(fe);
    drain(per);
    check_eq("err_set", {31'b0, err_pad}, 32'd1);
    start_frame(f3);
    drain(per);
    check_eq("err_sticky", {31'b0, err_pad}, 32'd1);

    // Counter wrap from 0xFFFF.
    force dut.frame_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.frame_cnt_q;
    @(negedge clk);
    check_eq("cnt_preload", {16'b0, frame_cnt}, 32'h0000FFFF);
    m_cnt = 16'hFFFF;
    start_frame(f2);
    drain(per);
    check_eq("cnt_wrap", {16'b0, frame_cnt}, 32'd0);

    // Random frames under random backpressure.
    rnd_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      start_frame(pack_frame(18'($urandom), 11'($urandom), 18'($urandom),
                             22'($urandom), 12'($urandom), 1'b0));
      drain(per);
    end
    rnd_ready = 1'b0;

    // Reset in the middle of a frame.
    start_frame(f3);
    for (n = 0; n < 100 && beat_in_frame != 5; n++) @(negedge clk);
    if (beat_in_frame != 5) check_eq("beat5_timeout", beat_in_frame, 32'd5);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("mrst_out_valid", {31'b0, out_valid}, 32'd0);
    check_eq("mrst_in_ready", {31'b0, in_ready}, 32'd1);
    check_eq("mrst_sig", sig, 32'd0);
    check_eq("mrst_cnt", {16'b0, frame_cnt}, 32'd0);
    check_eq("mrst_err", {31'b0, err_pad}, 32'd0);
    rst = 1'b0;
    m_sig = '0; m_cnt = '0; m_err = 1'b0;
    @(negedge clk);
    start_frame(f2);
    drain(per);
    check_eq("post_rst_sig", sig, 32'h000200A4);
    check_eq("post_rst_cnt", {16'b0, frame_cnt}, 32'd1);

    repeat (3) @(negedge clk);
    check_eq("queue_empty", expq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/fuzz_frame_serializer.md
Name: fuzz_frame_serializer

Overview:
- Consumer end of the fuzz-result bus: accepts one 82-bit packed result frame per handshake and streams it out LSB-first as 8-bit beats toward the capture/compare host.
- Maintains a running 32-bit signature, a frame counter and a sticky pad-bit error, so that simulator-vs-synthesis runs can be compared without dumping every frame.
- Sits between the fuzz DUT output register and the trace link.

Parameters:
- FRAME_W, 82: packed result frame width.
- BEAT_W, 8: output beat width.
- CNT_W, 16: frame counter width.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  frame present
- in_ready  out  1  block can accept a frame
- in_frame  in  FRAME_W  packed frame: [81:64] f9 (low 18b), [63:53] f8, [52:35] f7, [34:13] f6, [12:1] f5, [0] pad (must be 0)
- out_valid  out  1  beat present
- out_ready  in  1  sink accepts beat
- out_data  out  BEAT_W  current beat
- out_last  out  1  final beat of frame
- sig  out  32  running signature
- frame_cnt  out  CNT_W  accepted-frame count
- err_pad  out  1  sticky: an accepted frame had pad bit = 1

Behaviour:
- Reset is synchronous, active-high, and applies mid-frame as well. Reset values: state IDLE, in_ready=1, out_valid=0, out_last=0, out_data=0, sig=0, frame_cnt=0, err_pad=0. A partial frame in flight is discarded.
- States:
  - IDLE: in_ready=1, out_valid=0. On in_valid&in_ready, load in_frame zero-extended to 88b into shift reg, beat_idx=0, go to SEND.
  - SEND: in_ready=0, out_valid=1, out_data=shreg[7:0].
    - On out_valid&out_ready: shift right 8, beat_idx+1.
    - If the current beat is the last, go to IDLE instead.
- NBEATS=ceil(82/8)=11. Beat 10 carries bits [81:80] in out_data[1:0]; out_data[7:2]=0.
- out_last=1 only while beat_idx==10 (feature off).
- Backpressure: while out_ready=0, out_data, out_last and beat_idx hold. No beat is skipped or duplicated.
- Latency: first beat is valid the cycle after acceptance. in_ready rises the cycle after the last beat handshake. Minimum period is 12 cycles per frame (feature off); no overlap.
- On accept, all three updates occur in the same cycle:
  - frame_cnt+1, wrapping 0xFFFF->0x0000.
  - sig <= {sig[30:0],sig[31]} ^ fold, where fold = w0^w1^w2 over the frame zero-extended to 96b (w0=[31:0], w1=[63:32], w2=[95:64]).
  - err_pad |= in_frame[0].
- in_valid while not IDLE is ignored (in_ready=0). in_frame changes during SEND have no effect.
- out_ready high in IDLE has no effect.

Optional Feature:
- Macro FUZZ_FRAME_PARITY_EN.
- Defined: one extra beat (index 11) follows the data beats. It equals the XOR of the 11 data beats. out_last moves to beat 11, and the frame period becomes 13 cycles.
- Undefined: 11 beats, no parity beat.
- sig, frame_cnt and err_pad are unaffected by the feature.

Decomposition:
- Package fuzz_frame_pkg:
  - FRAME_W, BEAT_W, NBEATS, SIG_W.
  - Field offset/width constants for f5..f9 and pad.
  - State enum {IDLE, SEND}.
- Sub-module fuzz_sig_fold: combinational; inputs frame and old sig, output next sig. Reused by the host-side checker model.

Test Plan:
- Reset mid-SEND (rst high 2 cycles at beat 5) -> out_valid=0, in_ready=1, sig=0, frame_cnt=0, err_pad=0. Next frame starts at beat 0.
- in_frame=82'h2_0000_0000_0000_0000_00A4, out_ready=1 -> beats A4, 00×9, 02, with out_last on beat 10. sig=0x000200A4, frame_cnt=1, err_pad=0.
- Same frame again -> sig=0x000601EC, frame_cnt=2.
- out_ready=0 for 3 cycles at beat 4 -> out_data and out_last stable, 11 beats total. in_valid held high throughout is not accepted until IDLE.
- Frame with bit0=1 -> err_pad=1 and stays set after subsequent clean frames. Preload frame_cnt to 0xFFFF by 65535 frames, or force it -> wraps to 0.
- FUZZ_FRAME_PARITY_EN, frame of test 2 -> beat 11 = 0xA6 with out_last, beat 10 out_last=0. in_ready returns 13 cycles after accept.
